dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder (target side) for the pipelined CPU's load/store path.
- Accepts one word-wide read or write request at a time using a valid/ready handshake.
- Inserts a programmable number of wait states, then returns exactly one single-cycle response carrying read data and an error flag.
- Replaces the fixed one-cycle RAM so that the CPU stall logic can be exercised against variable memory latency.

Parameters:
- ADDR_BASE, 32'h10010000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit storage words.
- WAIT_CYCLES, 2, wait states between accept and response (0 to 15 legal).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_ready  output  1  responder can accept a request this cycle.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  request was misaligned or out of range.

Behaviour:
- FSM states and transitions:
  - IDLE -> WAIT on accept (req_valid & req_ready at a rising edge). With WAIT_CYCLES = 0, IDLE goes directly to RESP.
  - WAIT -> RESP after WAIT_CYCLES cycles spent in WAIT, counted by a 4-bit down-counter loaded at accept.
  - RESP -> IDLE unconditionally after one cycle.
- Accept latches req_we, req_addr and req_wdata. Later changes on the request inputs are ignored.
- Timing:
  - Request accepted at edge T: resp_valid is high during cycle T+1+WAIT_CYCLES.
  - req_ready is high only in IDLE.
  - Minimum spacing between accepts is WAIT_CYCLES+2 cycles.
- Registered outputs:
  - req_ready is registered.
  - resp_valid, resp_rdata and resp_err are registered; they are valid only while resp_valid = 1 and are 0 otherwise.
- Address check, evaluated on the latched address:
  - err = (addr[1:0] != 0) | (addr < ADDR_BASE) | ((addr - ADDR_BASE) >= DEPTH_WORDS*4).
  - The comparisons are unsigned 32-bit. An address below ADDR_BASE must flag err and must not wrap.
- Index = (addr - ADDR_BASE) >> 2, truncated to clog2(DEPTH_WORDS) bits.
- Access point:
  - The array is read or written at the edge that enters RESP.
  - A store writes the array only if err = 0.
  - A load returns the array word, or 0 if err = 1.
  - A store always returns resp_rdata = 0.
- Ordering: a load following a store to the same address returns the stored data, since there is no overlap between requests.
- Reset values: state IDLE, req_ready 0 (rising to 1 the cycle after reset falls), resp_valid 0, resp_rdata 0, resp_err 0, counter 0.
- Reset mid-operation:
  - The in-flight request is dropped with no response.
  - A store whose access edge had not yet occurred is not performed.
- Storage contents are not cleared by reset.
- A request with req_valid high while req_ready is 0 is neither accepted nor queued. The requester must hold the request until ready.

Optional Feature:
- Macro: DMEM_BYTE_STROBE_EN.
- When defined:
  - Adds input req_be[3:0], latched at accept.
  - A store writes only the byte lanes whose strobe bit is 1 (bit i selects bits 8i+7:8i).
  - A store with req_be = 4'b0000 writes nothing and still responds.
  - Loads ignore req_be.
- When undefined: the port does not exist and every store writes all 32 bits.

Test Plan:
- Reset held 3 cycles, then released:
  - req_ready = 0 through the first cycle after release, then 1.
  - resp_valid, resp_rdata and resp_err = 0 throughout.
- WAIT_CYCLES = 2, store 32'hDEADBEEF to 32'h10010008 accepted at edge T:
  - resp_valid high only in cycle T+3, resp_err 0, resp_rdata 0.
  - A following load of 32'h10010008 returns 32'hDEADBEEF.
- Error cases, each with resp_err = 1:
  - Load of 32'h1001000A returns resp_rdata 0.
  - Store to 32'h1000FFFC leaves memory unchanged.
  - Store to ADDR_BASE + 4096 with DEPTH_WORDS = 1024 leaves memory unchanged.
- WAIT_CYCLES = 0 with req_valid held high continuously:
  - Accepts occur every 2 cycles.
  - resp_valid is high in the cycle after each accept.
  - The address changed while req_ready = 0 is ignored.
- Reset asserted during WAIT of a store of 32'h12345678 to 32'h10010010: no response, and a later load returns the previous contents.
- With DMEM_BYTE_STROBE_EN defined: word 32'hAABBCCDD, then a store of 32'h11223344 with req_be = 4'b0101, then a load returns 32'hAA22CC44.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, one-cycle response.
// Optional byte-lane store strobes are enabled with the DMEM_BYTE_STROBE_EN macro.
module dmem_responder #(
   parameter logic [31:0] ADDR_BASE   = 32'h1001_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
   input  logic [3:0]  req_be,
`endif
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [3:0]         cnt_q;
   logic [3:0]         cnt_d;
   logic               accept;

   logic               lat_we_q;
   logic [31:0]        lat_addr_q;
   logic [31:0]        lat_wdata_q;
`ifdef DMEM_BYTE_STROBE_EN
   logic [3:0]         lat_be_q;
   logic [3:0]         acc_be;
`endif

   logic               acc_from_req;
   logic               acc_we;
   logic [31:0]        acc_addr;
   logic [31:0]        acc_wdata;
   logic [31:0]        acc_off;
   logic               acc_err;
   logic [IDX_W-1:0]   acc_idx;
   logic               do_access;
   logic               ready_d;

   logic [31:0]        mem [DEPTH_WORDS];

   // Next-state logic and wait-state counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = req_valid & req_ready;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cnt_d   = WAIT_LOAD;
               state_d = (WAIT_LOAD == 4'd0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // With zero wait states the access edge is the accept edge, so the live request is used
   always_comb begin
      acc_from_req = (state_q == ST_IDLE);
      acc_we       = acc_from_req ? req_we    : lat_we_q;
      acc_addr     = acc_from_req ? req_addr  : lat_addr_q;
      acc_wdata    = acc_from_req ? req_wdata : lat_wdata_q;
`ifdef DMEM_BYTE_STROBE_EN
      acc_be       = acc_from_req ? req_be    : lat_be_q;
`endif
      acc_off      = acc_addr - ADDR_BASE;
      acc_err      = (acc_addr[1:0] != 2'b00) | (acc_addr < ADDR_BASE) | (acc_off >= SPAN_BYTES);
      acc_idx      = IDX_W'(acc_off >> 2);
      do_access    = (state_d == ST_RESP) && (state_q != ST_RESP);
      ready_d      = (state_d == ST_IDLE);
   end

   // State, request latch and registered response
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         req_ready   <= 1'b0;
         resp_valid  <= 1'b0;
         resp_rdata  <= 32'd0;
         resp_err    <= 1'b0;
         lat_we_q    <= 1'b0;
         lat_addr_q  <= 32'd0;
         lat_wdata_q <= 32'd0;
`ifdef DMEM_BYTE_STROBE_EN
         lat_be_q    <= 4'd0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_ready  <= ready_d;
         resp_valid <= do_access;
         resp_err   <= do_access & acc_err;
         resp_rdata <= (do_access && !acc_we && !acc_err) ? mem[acc_idx] : 32'd0;
         if (accept) begin
            lat_we_q    <= req_we;
            lat_addr_q  <= req_addr;
            lat_wdata_q <= req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
            lat_be_q    <= req_be;
`endif
         end
      end
   end

   // Storage is not reset; a store lands only on an error-free access edge outside reset
   always_ff @(posedge clk) begin
      if (!reset && do_access && acc_we && !acc_err) begin
`ifdef DMEM_BYTE_STROBE_EN
         for (int b = 0; b < 4; b++) begin
            if (acc_be[b]) begin
               mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
         end
`else
         mem[acc_idx] <= acc_wdata;
`endif
      end
   end

endmodule
